// File: rtl/mix_columns_pkg.sv
// mix_columns_pkg
// Shared definitions for the AES MixColumns round stage:
//   - state / column geometry (128-bit state, four 32-bit columns)
//   - AES field reduction constant for x^8 + x^4 + x^3 + x + 1
//   - FSM state encoding for the iterative column engine
//   - xtime(): multiply-by-x in GF(2^8), shared with key expansion
package mix_columns_pkg;

    localparam int STATE_W  = 128;
    localparam int COL_W    = 32;
    localparam int NUM_COLS = 4;
    localparam int IDX_W    = $clog2(NUM_COLS);

    // Low byte of the reduction polynomial 0x11B; the x^8 term is implied.
    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2
    } mc_state_e;

    // Multiply a field element by x, folding the overflow back with 0x1B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/mix_columns_column.sv
// mix_single_column
// Purely combinational transform of one 32-bit AES column.
//   col_in  : column, row 0 byte in bits [31:24]
//   encrypt : 1 = MixColumns matrix [02 03 01 01], 0 = InvMixColumns [0E 0B 0D 09]
//   col_out : transformed column, same byte ordering as col_in
// Every product is built from xtime chains (x2, x4, x8) plus XOR.
module mix_single_column
    import mix_columns_pkg::*;
(
    input  logic [COL_W-1:0] col_in,
    input  logic             encrypt,
    output logic [COL_W-1:0] col_out
);

    logic [7:0] b_s  [4];
    logic [7:0] x2_s [4];
    logic [7:0] x4_s [4];
    logic [7:0] x8_s [4];

    // Split the column into rows and build the xtime ladder for each byte.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            b_s[r]  = col_in[31-8*r -: 8];
            x2_s[r] = xtime(b_s[r]);
            x4_s[r] = xtime(x2_s[r]);
            x8_s[r] = xtime(x4_s[r]);
        end
    end

    // Row r multiplies the rotated coefficient row against bytes r, r+1, r+2, r+3.
    always_comb begin
        logic [1:0] k0;
        logic [1:0] k1;
        logic [1:0] k2;
        logic [1:0] k3;
        col_out = {COL_W{1'b0}};
        for (int r = 0; r < 4; r++) begin
            k0 = 2'(r);
            k1 = k0 + 2'd1;
            k2 = k0 + 2'd2;
            k3 = k0 + 2'd3;
            if (encrypt) begin
                // 02*b0 ^ 03*b1 ^ 01*b2 ^ 01*b3
                col_out[31-8*r -: 8] = x2_s[k0]
                                     ^ (x2_s[k1] ^ b_s[k1])
                                     ^ b_s[k2]
                                     ^ b_s[k3];
            end else begin
                // 0E*b0 ^ 0B*b1 ^ 0D*b2 ^ 09*b3
                col_out[31-8*r -: 8] = (x8_s[k0] ^ x4_s[k0] ^ x2_s[k0])
                                     ^ (x8_s[k1] ^ x2_s[k1] ^ b_s[k1])
                                     ^ (x8_s[k2] ^ x4_s[k2] ^ b_s[k2])
                                     ^ (x8_s[k3] ^ b_s[k3]);
            end
        end
    end

endmodule

// File: rtl/mix_columns.sv
// mix_columns
// Iterative AES (Inv)MixColumns stage: one column per clock through a single
// shared column datapath, with a one-cycle bypass path for the final round.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   in         : 128-bit state, column c = in[127-32c -: 32]
//   ready      : start pulse; in/encrypt/bypass sampled with it (ignored while busy)
//   encrypt    : 1 = MixColumns, 0 = InvMixColumns
//   bypass     : 1 = return the state unchanged
//   out        : result, held until the next done
//   done       : one-cycle completion pulse, out valid with it
//   busy       : block in flight
module mix_columns
    import mix_columns_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [STATE_W-1:0] in,
    input  logic               ready,
    input  logic               encrypt,
    input  logic               bypass,
    output logic [STATE_W-1:0] out,
    output logic               done,
    output logic               busy
);

    mc_state_e          fsm_q,   fsm_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic               enc_q,   enc_d;
    logic [STATE_W-1:0] out_q,   out_d;
    logic               done_q,  done_d;
    logic               busy_q,  busy_d;

    logic [COL_W-1:0]   col_in_s;
    logic [COL_W-1:0]   col_out_s;

    // Select the column addressed by the running index.
    always_comb begin
        case (idx_q)
            2'd0:    col_in_s = state_q[127:96];
            2'd1:    col_in_s = state_q[95:64];
            2'd2:    col_in_s = state_q[63:32];
            2'd3:    col_in_s = state_q[31:0];
            default: col_in_s = {COL_W{1'b0}};
        endcase
    end

    mix_single_column u_column (
        .col_in  (col_in_s),
        .encrypt (enc_q),
        .col_out (col_out_s)
    );

    // Next-state logic for the FSM, column index, state and output registers.
    always_comb begin
        fsm_d   = fsm_q;
        idx_d   = idx_q;
        state_d = state_q;
        enc_d   = enc_q;
        out_d   = out_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        case (fsm_q)
            ST_IDLE: begin
                if (ready) begin
                    state_d = in;
                    enc_d   = encrypt;
                    busy_d  = 1'b1;
                    idx_d   = {IDX_W{1'b0}};
                    fsm_d   = bypass ? ST_PASS : ST_RUN;
                end else begin
                    idx_d   = {IDX_W{1'b0}};
                end
            end
            ST_RUN: begin
                case (idx_q)
                    2'd0:    state_d[127:96] = col_out_s;
                    2'd1:    state_d[95:64]  = col_out_s;
                    2'd2:    state_d[63:32]  = col_out_s;
                    2'd3:    state_d[31:0]   = col_out_s;
                    default: state_d         = state_q;
                endcase
                // 2-bit index wraps to 0 on the final column.
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    // state_d already carries the freshly mixed last column.
                    out_d  = state_d;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    fsm_d  = ST_IDLE;
                end else begin
                    fsm_d  = ST_RUN;
                end
            end
            ST_PASS: begin
                out_d  = state_q;
                done_d = 1'b1;
                busy_d = 1'b0;
                fsm_d  = ST_IDLE;
            end
            default: begin
                fsm_d  = ST_IDLE;
                idx_d  = {IDX_W{1'b0}};
                busy_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q   <= ST_IDLE;
            idx_q   <= {IDX_W{1'b0}};
            state_q <= {STATE_W{1'b0}};
            enc_q   <= 1'b0;
            out_q   <= {STATE_W{1'b0}};
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            idx_q   <= idx_d;
            state_q <= state_d;
            enc_q   <= enc_d;
            out_q   <= out_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign out  = out_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_mix_columns.sv
// tb_mix_columns
// Directed and randomized checks of the mix_columns stage against a
// behavioural GF(2^8) matrix model (generic shift-and-add field multiply).
module tb_mix_columns;

    logic         clk;
    logic         reset;
    logic [127:0] in_v;
    logic         ready;
    logic         encrypt;
    logic         bypass;
    logic [127:0] out_v;
    logic         done;
    logic         busy;

    int tests;
    int failed;

    mix_columns dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in_v),
        .ready   (ready),
        .encrypt (encrypt),
        .bypass  (bypass),
        .out     (out_v),
        .done    (done),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generic GF(2^8) multiply, reduced by 0x11B.
    function automatic int gmul(input int a, input int b);
        int p;
        int aa;
        p  = 0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (((b >> i) & 1) != 0) p = p ^ aa;
            aa = aa << 1;
            if ((aa & 'h100) != 0) aa = aa ^ 'h11B;
        end
        return p & 'hFF;
    endfunction

    // Reference (Inv)MixColumns on a whole 128-bit state.
    function automatic logic [127:0] mix_ref(input logic [127:0] s, input bit enc);
        int coef [4];
        int acc;
        logic [127:0] r;
        logic [7:0] bt;
        if (enc) begin
            coef[0] = 2;  coef[1] = 3;  coef[2] = 1;  coef[3] = 1;
        end else begin
            coef[0] = 14; coef[1] = 11; coef[2] = 13; coef[3] = 9;
        end
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 0;
                for (int k = 0; k < 4; k++) begin
                    bt  = s[127 - 32*c - 8*k -: 8];
                    acc = acc ^ gmul(coef[(k - row + 4) % 4], int'(bt));
                end
                r[127 - 32*c - 8*row -: 8] = 8'(acc);
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one block, scramble the inputs after acceptance, and check timing/result.
    task automatic run_block(input logic [127:0] vin, input bit ven, input bit vbyp,
                             input logic [127:0] exp, input string tag);
        int lat;
        int busy_cyc;
        in_v = vin; encrypt = ven; bypass = vbyp; ready = 1'b1;
        step();
        ready = 1'b0; encrypt = ~ven; bypass = ~vbyp; in_v = rand128();
        lat = 0;
        busy_cyc = 0;
        while (done !== 1'b1 && lat < 16) begin
            if (busy === 1'b1) busy_cyc++;
            step();
            lat++;
        end
        check({tag, " done"}, 128'(done), 128'(1));
        check({tag, " latency"}, 128'(lat), vbyp ? 128'(1) : 128'(4));
        check({tag, " busy_cycles"}, 128'(busy_cyc), vbyp ? 128'(1) : 128'(4));
        check({tag, " out"}, out_v, exp);
        check({tag, " busy_at_done"}, 128'(busy), 128'(0));
        step();
        check({tag, " done_pulse"}, 128'(done), 128'(0));
        check({tag, " out_held"}, out_v, exp);
    endtask

    logic [127:0] fips_in;
    logic [127:0] fips_out;
    logic [127:0] a_v;
    logic [127:0] f_v;
    logic [127:0] vals [12];
    logic [127:0] exp_q [$];
    logic [127:0] got_q [$];
    int           next_acc;
    int           done_cnt;
    int           dbl_cnt;
    bit           prev_done;
    int           wait_cyc;

    initial begin
        tests = 0; failed = 0;
        fips_in  = 128'hdb135345_f20a225c_01010101_2d26314c;
        fips_out = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
        reset = 1'b1; ready = 1'b0; encrypt = 1'b1; bypass = 1'b0; in_v = '0;
        step(); step();
        reset = 1'b0;
        check("reset out", out_v, 128'h0);
        check("reset done", 128'(done), 128'(0));
        check("reset busy", 128'(busy), 128'(0));
        step();
        check("idle done", 128'(done), 128'(0));

        // Known-answer vectors, model cross-check, bypass with either encrypt value.
        check("model fwd", mix_ref(fips_in, 1'b1), fips_out);
        run_block(fips_in, 1'b1, 1'b0, fips_out, "fwd_fips");
        run_block(fips_out, 1'b0, 1'b0, fips_in, "inv_fips");
        run_block(128'h00112233_44556677_8899aabb_ccddeeff, 1'b1, 1'b1,
                  128'h00112233_44556677_8899aabb_ccddeeff, "bypass_e1");
        run_block(128'h00112233_44556677_8899aabb_ccddeeff, 1'b0, 1'b1,
                  128'h00112233_44556677_8899aabb_ccddeeff, "bypass_e0");

        // ready asserted while busy, including at the completion edge.
        in_v = fips_in; encrypt = 1'b1; bypass = 1'b0; ready = 1'b1;
        step();
        in_v = rand128(); bypass = 1'b1;
        wait_cyc = 0;
        while (done !== 1'b1 && wait_cyc < 16) begin
            step();
            wait_cyc++;
        end
        ready = 1'b0;
        check("busy_ready done", 128'(done), 128'(1));
        check("busy_ready out", out_v, fips_out);
        step();
        check("busy_ready no_capture", 128'(busy), 128'(0));
        check("busy_ready done_low", 128'(done), 128'(0));

        // ready held high for 12 cycles with changing input.
        encrypt = 1'b1; bypass = 1'b0;
        next_acc = 0; done_cnt = 0; dbl_cnt = 0; prev_done = 1'b0;
        exp_q.delete(); got_q.delete();
        for (int k = 0; k < 12; k++) begin
            vals[k] = rand128();
            in_v = vals[k]; ready = 1'b1;
            if (k == next_acc) begin
                exp_q.push_back(mix_ref(vals[k], 1'b1));
                next_acc = k + 5;
            end
            step();
            if (done === 1'b1) begin
                done_cnt++;
                got_q.push_back(out_v);
                if (prev_done) dbl_cnt++;
            end
            prev_done = (done === 1'b1);
        end
        ready = 1'b0;
        check("held done_count", 128'(done_cnt), 128'(2));
        check("held no_double", 128'(dbl_cnt), 128'(0));
        wait_cyc = 0;
        while (done !== 1'b1 && wait_cyc < 16) begin
            step();
            wait_cyc++;
        end
        if (done === 1'b1) got_q.push_back(out_v);
        check("held total", 128'(got_q.size()), 128'(3));
        for (int i = 0; i < 3; i++) begin
            if (i < got_q.size()) check($sformatf("held blk%0d", i), got_q[i], exp_q[i]);
            else check($sformatf("held blk%0d missing", i), 128'(0), 128'(1));
        end
        step();

        // Reset asserted at the E2 edge of a forward block.
        in_v = fips_in; encrypt = 1'b1; bypass = 1'b0; ready = 1'b1;
        step();
        ready = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midreset done", 128'(done), 128'(0));
        check("midreset busy", 128'(busy), 128'(0));
        check("midreset out", out_v, 128'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("midreset no_done", 128'(done), 128'(0));
        end
        run_block(128'hd4d4d4d5_c6c6c6c6_01010101_2d26314c, 1'b1, 1'b0,
                  128'hd5d5d7d6_c6c6c6c6_01010101_4d7ebdf8, "post_reset");

        // Random forward/inverse chains.
        for (int n = 0; n < 1000; n++) begin
            a_v = rand128();
            f_v = mix_ref(a_v, 1'b1);
            run_block(a_v, 1'b1, 1'b0, f_v, "rand_fwd");
            run_block(out_v, 1'b0, 1'b0, a_v, "rand_inv");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mix_columns.md
Name: mix_columns

Overview:
- AES round stage that applies MixColumns (encrypt=1) or InvMixColumns (encrypt=0) to a 128-bit state.
- Iterative: processes one 32-bit column per clock through a single shared column datapath, trading latency for area.
- Sits downstream of the byte-substitution/shift-rows path and upstream of add-round-key.
- Uses the same ready-in / done-out pulse handshake as the neighbouring stages, plus a busy flag and a bypass for the final round.

Parameters:
- None. State width is fixed at 128 bits, 4 columns, 32 bits per column.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in  input  128  state in; column c = in[127-32c -: 32]; row 0 byte is the MSB of each column
- ready  input  1  one-cycle start pulse; in, encrypt and bypass are sampled with it
- encrypt  input  1  1 = MixColumns, 0 = InvMixColumns
- bypass  input  1  1 = pass state unchanged (AES final round)
- out  output  128  result, held stable until the next done
- done  output  1  one-cycle pulse; out is valid in the same cycle
- busy  output  1  high while a block is in flight; ready is ignored while busy=1

Behaviour:
- Reset is synchronous and active-high on clk; single clock domain. Reset values: out=0, done=0, busy=0, FSM=IDLE, column index=0.
- FSM has three states: IDLE, RUN, PASS.
- IDLE:
  - On ready=1 at edge E0: capture in into the internal state register, and latch encrypt and bypass.
  - Set busy=1 and column index=0.
  - Go to PASS if bypass=1, else RUN.
  - With ready=0, stay in IDLE and keep done=0.
- RUN, each edge:
  - Replace column[idx] with the column-datapath result and increment idx (2-bit).
  - At the edge where idx=3 (E4): out <= {columns 0..2 from state, new column 3}, done<=1, busy<=0, go to IDLE, idx wraps to 0.
- PASS: at the next edge (E1), out <= captured state, done<=1, busy<=0, go to IDLE.
- Latency:
  - Non-bypass: done asserts after edge E0+4.
  - Bypass: done asserts after edge E0+1.
  - Throughput is one block per 5 cycles (non-bypass) or 2 cycles (bypass); ready is accepted again in the cycle after done.
- done is high for exactly one cycle and is cleared on the next edge unless a new completion occurs.
- Boundary conditions:
  - ready while busy=1 (including the done cycle's edge): ignored; no capture, and in-flight data is unaffected.
  - ready held high continuously: a new block starts on the first edge with busy=0.
  - encrypt or bypass changing mid-block: no effect; the latched values are used.
  - reset mid-operation: block abandoned, all outputs return to reset values, FSM=IDLE, no done pulse.
- Column arithmetic is GF(2^8) with polynomial 0x11B.
  - xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0).
  - Forward MixColumns matrix rows: [02 03 01 01], rotated per row.
  - InvMixColumns matrix rows: [0E 0B 0D 09], rotated per row, built from xtime chains (x2, x4, x8).
  - Purely combinational within one cycle; no registered intermediate stages.

Decomposition:
- Shared package holds:
  - the AES reduction constant 0x1B;
  - the state/column widths (128/32);
  - the FSM state encoding (IDLE, RUN, PASS);
  - a xtime function reusable by key expansion.
- The natural sub-module is mix_single_column: combinational; ports are a 32-bit column in, encrypt, and a 32-bit column out.
- The parent holds the FSM, index counter, state register and output registers.

Test Plan:
- Forward, FIPS-197 vector: in=db135345_f20a225c_01010101_2d26314c, encrypt=1, bypass=0, ready pulse → done one cycle only, 4 edges after the capture edge; out=8e4da1bc_9fdc589d_01010101_4d7ebdf8; busy high for exactly those 4 cycles.
- Inverse: in=8e4da1bc_9fdc589d_01010101_4d7ebdf8, encrypt=0 → out=db135345_f20a225c_01010101_2d26314c after the same latency. Also chain forward→inverse on 1000 random states and require equality with the original.
- Bypass: in=00112233_44556677_8899aabb_ccddeeff, bypass=1 → done 1 edge after capture, out equal to in; encrypt value irrelevant.
- Handshake:
  - ready held high for 12 cycles with a changing in → exactly two completed blocks, each taking the in value at its accept edge.
  - No capture while busy.
  - done never high for 2 consecutive cycles.
- Reset mid-block: assert reset at E2 of a forward block → next cycle done=0, busy=0, out=0. A following block using the vector d4d4d4d5_c6c6c6c6_01010101_2d26314c gives d5d5d7d6_c6c6c6c6_01010101_4d7ebdf8.
